// File: rtl/wb_arbiter_2m_pkg.sv
// Shared types and encodings for the two-master burst arbiter wb_arbiter_2m.
// Optional round-robin policy is enabled by defining WB_ARB_ROUND_ROBIN_EN.
package wb_arbiter_2m_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned BC_W   = 3;

    typedef enum logic [1:0] {
        STATE_IDLE      = 2'd0,
        STATE_WRITE     = 2'd1,
        STATE_READ_CMD  = 2'd2,
        STATE_READ_DATA = 2'd3
    } state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Command-side payload of one master, muxed as a unit onto the shared port.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
        logic [BC_W-1:0]   burstcount;
        logic              write;
        logic              read;
    } wb_cmd_t;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [BC_W-1:0] burst_beats(input logic [BC_W-1:0] bc);
        return (bc == '0) ? BC_W'(1) : bc;
    endfunction

endpackage

// File: rtl/wb_arbiter_2m_pick.sv
// Arbitration policy for wb_arbiter_2m: chooses a winner from two requests.
// Fixed master-0 priority by default; round-robin when WB_ARB_ROUND_ROBIN_EN is defined.
module wb_arb_pick
    import wb_arbiter_2m_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       grant_owner
);

`ifdef WB_ARB_ROUND_ROBIN_EN
    // On a tie the master that did not own the last burst wins.
    always_comb begin
        grant_valid = |req;
        grant_owner = OWNER_M0;
        if (req == 2'b11) begin
            grant_owner = ~last_owner;
        end else if (req == 2'b10) begin
            grant_owner = OWNER_M1;
        end
    end
`else
    // Master 0 wins every tie; history is kept upstream but not consulted.
    wire unused_last_owner = last_owner;

    always_comb begin
        grant_valid = |req;
        grant_owner = OWNER_M0;
        if (req == 2'b10) begin
            grant_owner = OWNER_M1;
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master arbiter for a pipelined waitrequest/readdatavalid burst port; the
// grant is held for a whole burst. Policy selectable with WB_ARB_ROUND_ROBIN_EN.
module wb_arbiter_2m
    import wb_arbiter_2m_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_address_i,
    input  logic [DATA_W-1:0] m0_writedata_i,
    input  logic [BE_W-1:0]   m0_byteenable_i,
    input  logic [BC_W-1:0]   m0_burstcount_i,
    input  logic              m0_write_i,
    input  logic              m0_read_i,
    output logic              m0_waitrequest_o,
    output logic              m0_readdatavalid_o,
    output logic [DATA_W-1:0] m0_readdata_o,

    input  logic [ADDR_W-1:0] m1_address_i,
    input  logic [DATA_W-1:0] m1_writedata_i,
    input  logic [BE_W-1:0]   m1_byteenable_i,
    input  logic [BC_W-1:0]   m1_burstcount_i,
    input  logic              m1_write_i,
    input  logic              m1_read_i,
    output logic              m1_waitrequest_o,
    output logic              m1_readdatavalid_o,
    output logic [DATA_W-1:0] m1_readdata_o,

    output logic [ADDR_W-1:0] s_address_o,
    output logic [DATA_W-1:0] s_writedata_o,
    output logic [BE_W-1:0]   s_byteenable_o,
    output logic [BC_W-1:0]   s_burstcount_o,
    output logic              s_write_o,
    output logic              s_read_o,
    input  logic              s_waitrequest_i,
    input  logic              s_readdatavalid_i,
    input  logic [DATA_W-1:0] s_readdata_i
);

    state_e          state_q,      state_d;
    logic            owner_q,      owner_d;
    logic            last_owner_q, last_owner_d;
    logic [BC_W-1:0] beats_q,      beats_d;

    wb_cmd_t    m0_cmd, m1_cmd, sel_cmd, win_cmd;
    logic [1:0] req;
    logic       grant_valid, grant_owner;
    logic       cmd_phase;
    logic [1:0] waitrequest_c, readdatavalid_c;

    assign m0_cmd = '{address: m0_address_i, writedata: m0_writedata_i,
                      byteenable: m0_byteenable_i, burstcount: m0_burstcount_i,
                      write: m0_write_i, read: m0_read_i};
    assign m1_cmd = '{address: m1_address_i, writedata: m1_writedata_i,
                      byteenable: m1_byteenable_i, burstcount: m1_burstcount_i,
                      write: m1_write_i, read: m1_read_i};

    assign req = {m1_read_i | m1_write_i, m0_read_i | m0_write_i};

    wb_arb_pick u_pick (
        .req         (req),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Owner's command reaches the slave only in command phases; master 0 otherwise.
    assign cmd_phase = (state_q == STATE_WRITE) || (state_q == STATE_READ_CMD);
    assign sel_cmd   = (cmd_phase && (owner_q == OWNER_M1)) ? m1_cmd : m0_cmd;
    assign win_cmd   = (grant_owner == OWNER_M1) ? m1_cmd : m0_cmd;

    assign s_address_o    = sel_cmd.address;
    assign s_writedata_o  = sel_cmd.writedata;
    assign s_byteenable_o = sel_cmd.byteenable;
    assign s_burstcount_o = sel_cmd.burstcount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= STATE_IDLE;
            owner_q      <= OWNER_M0;
            last_owner_q <= OWNER_M1;
            beats_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beats_q      <= beats_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beats_d      = beats_q;
        unique case (state_q)
            STATE_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    if (win_cmd.write) begin
                        state_d = STATE_WRITE;
                        beats_d = burst_beats(win_cmd.burstcount);
                    end else begin
                        state_d = STATE_READ_CMD;
                    end
                end
            end
            STATE_WRITE: begin
                if (s_write_o && !s_waitrequest_i) begin
                    beats_d = beats_q - BC_W'(1);
                    if (beats_q == BC_W'(1)) begin
                        state_d      = STATE_IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            STATE_READ_CMD: begin
                if (s_read_o && !s_waitrequest_i) begin
                    state_d = STATE_READ_DATA;
                    beats_d = burst_beats(sel_cmd.burstcount);
                end
            end
            STATE_READ_DATA: begin
                if (s_readdatavalid_i) begin
                    beats_d = beats_q - BC_W'(1);
                    if (beats_q == BC_W'(1)) begin
                        state_d      = STATE_IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // Handshake routing: only the owner sees the slave; readdatavalid only in READ_DATA.
    always_comb begin
        s_write_o       = 1'b0;
        s_read_o        = 1'b0;
        waitrequest_c   = 2'b11;
        readdatavalid_c = 2'b00;
        unique case (state_q)
            STATE_WRITE: begin
                s_write_o              = sel_cmd.write;
                waitrequest_c[owner_q] = s_waitrequest_i;
            end
            STATE_READ_CMD: begin
                s_read_o               = sel_cmd.read;
                waitrequest_c[owner_q] = s_waitrequest_i;
            end
            STATE_READ_DATA: begin
                readdatavalid_c[owner_q] = s_readdatavalid_i;
            end
            default: ;
        endcase
    end

    assign m0_waitrequest_o   = waitrequest_c[0];
    assign m1_waitrequest_o   = waitrequest_c[1];
    assign m0_readdatavalid_o = readdatavalid_c[0];
    assign m1_readdatavalid_o = readdatavalid_c[1];
    assign m0_readdata_o      = s_readdata_i;
    assign m1_readdata_o      = s_readdata_i;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed scoreboard bench for wb_arbiter_2m; honours WB_ARB_ROUND_ROBIN_EN.
module tb_wb_arbiter_2m;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];
    logic [2:0]  m_bc    [2];
    logic        m_write [2];
    logic        m_read  [2];
    logic        m0_wrq, m1_wrq, m0_rdv, m1_rdv;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_address_o, s_writedata_o, s_readdata;
    logic [3:0]  s_byteenable_o;
    logic [2:0]  s_burstcount_o;
    logic        s_write_o, s_read_o, s_wait, s_rdv;

    wire [1:0] m_wrq = {m1_wrq, m0_wrq};
    wire [1:0] m_rdv = {m1_rdv, m0_rdv};

    wexp_t       wq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    int          rx_cnt [2];
    int          errors = 0;
    int          checks = 0;

    wb_arbiter_2m dut (
        .clk(clk), .rst(rst),
        .m0_address_i(m_addr[0]), .m0_writedata_i(m_wdata[0]), .m0_byteenable_i(m_be[0]),
        .m0_burstcount_i(m_bc[0]), .m0_write_i(m_write[0]), .m0_read_i(m_read[0]),
        .m0_waitrequest_o(m0_wrq), .m0_readdatavalid_o(m0_rdv), .m0_readdata_o(m0_rdata),
        .m1_address_i(m_addr[1]), .m1_writedata_i(m_wdata[1]), .m1_byteenable_i(m_be[1]),
        .m1_burstcount_i(m_bc[1]), .m1_write_i(m_write[1]), .m1_read_i(m_read[1]),
        .m1_waitrequest_o(m1_wrq), .m1_readdatavalid_o(m1_rdv), .m1_readdata_o(m1_rdata),
        .s_address_o(s_address_o), .s_writedata_o(s_writedata_o), .s_byteenable_o(s_byteenable_o),
        .s_burstcount_o(s_burstcount_o), .s_write_o(s_write_o), .s_read_o(s_read_o),
        .s_waitrequest_i(s_wait), .s_readdatavalid_i(s_rdv), .s_readdata_i(s_readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: accepted write beats and routed read beats.
    always @(negedge clk) begin
        wexp_t we;
        if (!rst) begin
            if (s_write_o && !s_wait) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    we = wq.pop_front();
                    chk("s_address", s_address_o, we.addr);
                    chk("s_writedata", s_writedata_o, we.data);
                    chk("s_byteenable", 32'(s_byteenable_o), 32'(we.be));
                end
            end
            if (m0_rdv) begin
                rx_cnt[0]++;
                if (rq0.size() == 0) chk("m0_rdv_unexpected", 1, 0);
                else chk("m0_readdata", m0_rdata, rq0.pop_front());
            end
            if (m1_rdv) begin
                rx_cnt[1]++;
                if (rq1.size() == 0) chk("m1_rdv_unexpected", 1, 0);
                else chk("m1_readdata", m1_rdata, rq1.pop_front());
            end
        end
    end

    task automatic do_write(input int m, input logic [31:0] addr, input logic [2:0] bc,
                            input logic [31:0] base, input logic [3:0] be,
                            input bit alt_wait, input bit stray);
        int  n = (bc == 3'd0) ? 1 : int'(bc);
        int  beat = 0;
        int  cyc = 0;
        bit  acc;
        logic own, other;
        for (int k = 0; k < n; k++) wq.push_back('{addr: addr, data: 32'(base + 32'(k)), be: be});
        m_addr[m] = addr; m_bc[m] = bc; m_be[m] = be; m_wdata[m] = base; m_write[m] = 1'b1;
        s_wait = 1'b0; s_rdv = stray;
        while (beat < n && cyc < 40) begin
            @(negedge clk);
            own   = (m == 1) ? m1_wrq : m0_wrq;
            other = (m == 1) ? m0_wrq : m1_wrq;
            acc   = !own;
            if (s_write_o) begin
                chk("owner_waitrequest", 32'(own), 32'(s_wait));
                chk("other_waitrequest", 32'(other), 1);
                chk("s_burstcount", 32'(s_burstcount_o), 32'(bc));
            end
            if (stray) chk("stray_rdv_write", 32'(m_rdv), 0);
            tick();
            if (acc) begin
                beat++;
                m_wdata[m] = 32'(base + 32'(beat));
            end
            if (beat == n) m_write[m] = 1'b0;
            if (alt_wait) s_wait = ~s_wait;
            cyc++;
        end
        chk("write_beats", 32'(beat), 32'(n));
        s_wait = 1'b0; s_rdv = 1'b0;
        @(negedge clk);
        chk("after_write_s_write", 32'(s_write_o), 0);
        chk("after_write_wrq", 32'(m_wrq), 32'(2'b11));
        tick();
    endtask

    task automatic issue_read(input int m, input logic [31:0] addr, input logic [2:0] bc);
        int  cyc = 0;
        bit  acc = 0;
        m_addr[m] = addr; m_bc[m] = bc; m_read[m] = 1'b1; s_wait = 1'b0;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            acc = !((m == 1) ? m1_wrq : m0_wrq);
            if (acc) begin
                chk("rd_s_read", 32'(s_read_o), 1);
                chk("rd_s_address", s_address_o, addr);
                chk("rd_s_burstcount", 32'(s_burstcount_o), 32'(bc));
            end
            tick();
            cyc++;
        end
        m_read[m] = 1'b0;
        chk("rd_accepted", 32'(acc), 1);
    endtask

    task automatic do_read(input int m, input logic [31:0] addr, input logic [2:0] bc,
                           input logic [31:0] d [4], input int gap [4]);
        int n = (bc == 3'd0) ? 1 : int'(bc);
        int rx0 = rx_cnt[m];
        int oth = rx_cnt[1-m];
        issue_read(m, addr, bc);
        for (int k = 0; k < n; k++) begin
            if (m == 1) rq1.push_back(d[k]); else rq0.push_back(d[k]);
        end
        for (int k = 0; k < n; k++) begin
            repeat (gap[k]) tick();
            s_rdv = 1'b1; s_readdata = d[k];
            tick();
            s_rdv = 1'b0;
        end
        tick();
        chk("read_beats", 32'(rx_cnt[m] - rx0), 32'(n));
        chk("read_other_beats", 32'(rx_cnt[1-m] - oth), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d [4];
        int          gap [4];
        int          req_left [2];
        int          gseq[$];
        int          gcyc[$];
        int          exp_seq[$];
        int          g, cyc;

        rst = 1'b1; s_wait = 1'b0; s_rdv = 1'b0; s_readdata = '0; rx_cnt = '{0, 0};
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = 4'hF; m_bc[i] = 3'd1;
            m_write[i] = 1'b0; m_read[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_write", 32'(s_write_o), 0);
        chk("rst_s_read", 32'(s_read_o), 0);
        chk("rst_wrq", 32'(m_wrq), 32'(2'b11));
        chk("rst_rdv", 32'(m_rdv), 0);
        tick();
        rst = 1'b0;
        tick();

        // m0 write burst of 4 with the slave stalling every other cycle
        do_write(0, 32'h0000_1000, 3'd4, 32'hD000_0000, 4'hF, 1'b1, 1'b0);

        // m1 read burst of 2 with a 3-cycle gap between beats
        d = '{32'hAAAA_5555, 32'h1234_5678, 32'h0, 32'h0};
        gap = '{1, 3, 0, 0};
        do_read(1, 32'h0000_2004, 3'd2, d, gap);

        // Simultaneous single-beat reads
`ifdef WB_ARB_ROUND_ROBIN_EN
        req_left = '{1, 1};
        exp_seq = '{0, 1};
`else
        req_left = '{2, 1};
        exp_seq = '{0, 0, 1};
`endif
        m_addr[0] = 32'h0000_3000; m_addr[1] = 32'h0000_4000;
        m_bc[0] = 3'd1; m_bc[1] = 3'd1;
        m_read[0] = 1'b1; m_read[1] = 1'b1;
        cyc = 0;
        while (gseq.size() < exp_seq.size() && cyc < 40) begin
            @(negedge clk);
            g = -1;
            if (m_read[0] && !m0_wrq) g = 0;
            if (m_read[1] && !m1_wrq) g = 1;
            if (g >= 0) chk("tie_s_address", s_address_o, m_addr[g]);
            tick();
            s_rdv = 1'b0;
            if (g >= 0) begin
                s_rdv = 1'b1; s_readdata = 32'hC000_0000 + 32'(cyc);
                if (g == 1) rq1.push_back(s_readdata); else rq0.push_back(s_readdata);
                req_left[g]--;
                if (req_left[g] == 0) m_read[g] = 1'b0;
                gseq.push_back(g); gcyc.push_back(cyc);
            end
            cyc++;
        end
        tick();
        s_rdv = 1'b0;
        tick();
        chk("tie_grant_count", 32'(gseq.size()), 32'(exp_seq.size()));
        for (int i = 0; i < gseq.size() && i < exp_seq.size(); i++) begin
            chk("tie_grant_owner", 32'(gseq[i]), 32'(exp_seq[i]));
            if (i > 0) chk("tie_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 3);
        end
        m_read[0] = 1'b0; m_read[1] = 1'b0;

        // burstcount 0 is a single beat
        do_write(0, 32'h0000_6000, 3'd0, 32'hB000_0000, 4'h3, 1'b0, 1'b0);

        // Stray readdatavalid while idle
        s_rdv = 1'b1; s_readdata = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk);
            chk("stray_rdv_idle", 32'(m_rdv), 0);
            tick();
        end
        s_rdv = 1'b0;

        // Stray readdatavalid during a 2-beat write must not disturb the beat count
        do_write(1, 32'h0000_7000, 3'd2, 32'hE000_0000, 4'hC, 1'b1, 1'b1);

        // Reset while two read beats are outstanding
        issue_read(1, 32'h0000_5000, 3'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_state", 32'(dut.state_q), 0);
        chk("midrst_wrq", 32'(m_wrq), 32'(2'b11));
        chk("midrst_s_read", 32'(s_read_o), 0);
        tick();
        rst = 1'b0;
        s_rdv = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_readdata = 32'h5A5A_0000 + 32'(k);
            @(negedge clk);
            chk("post_rst_rdv", 32'(m_rdv), 0);
            tick();
        end
        s_rdv = 1'b0;
        tick();

        chk("wq_drained", 32'(wq.size()), 0);
        chk("rq0_drained", 32'(rq0.size()), 0);
        chk("rq1_drained", 32'(rq1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
